// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage, single-entry or two-entry skid buffer, with flush and a saturating flush counter
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 7,
  parameter int SKID = 1,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       flush_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic rdy_q, in_xfer, out_xfer, load_main, load_skid;
  assign out_valid = state != EMPTY;
  assign in_ready = SKID != 0 ? rdy_q : (state == EMPTY || out_ready);
  assign out_ctrl = out_valid ? main_ctrl : NOP_CTRL;
  assign out_data = main_data;
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  // ONE with input only is reachable solely in skid mode; single-entry ready forces a simultaneous output
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (in_xfer ? ONE : EMPTY) :
               state == ONE ? (in_xfer && !out_xfer ? FULL : !in_xfer && out_xfer ? EMPTY : ONE) :
               state == FULL ? (out_xfer ? ONE : FULL) : EMPTY;
    load_main = !flush && (state == FULL ? out_xfer : in_xfer && (state == EMPTY || out_xfer));
    load_skid = !flush && state == ONE && in_xfer && !out_xfer;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      flush_cnt <= '0;
      main_ctrl <= NOP_CTRL;
      main_data <= '0;
      skid_ctrl <= NOP_CTRL;
      skid_data <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= state_nx != FULL;
      flush_cnt <= flush_cnt + 16'(flush && out_valid && flush_cnt != 16'hFFFF);
      if (load_main) begin
        main_ctrl <= state == FULL ? skid_ctrl : in_ctrl;
        main_data <= state == FULL ? skid_data : in_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks both buffer modes against a queue-based reference model
module tb_pipe_stage_reg;
  localparam logic [6:0] NOP0 = 7'h55;
  localparam logic [6:0] NOP1 = 7'h00;
  typedef logic [107:0] ent_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [6:0] in_ctrl = 0;
  logic [100:0] in_data = 0;
  logic r0, v0, r1, v1;
  logic [6:0] c0, c1;
  logic [100:0] d0, d1;
  logic [15:0] f0, f1;
  int checks = 0, fails = 0, outs0 = 0;
  ent_t q0[$], q1[$];
  logic [100:0] last0 = 0, last1 = 0;
  logic [15:0] cnt0 = 0, cnt1 = 0;
  logic [127:0] rnd;

  pipe_stage_reg #(.SKID(0), .NOP_CTRL(NOP0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v0), .out_ready(out_ready),
    .out_ctrl(c0), .out_data(d0), .flush_cnt(f0));
  pipe_stage_reg #(.SKID(1), .NOP_CTRL(NOP1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v1), .out_ready(out_ready),
    .out_ctrl(c1), .out_data(d1), .flush_cnt(f1));

  always #5 clk = ~clk;

  function automatic bit exp_rdy(bit skid, int n);
    return skid ? n < 2 : (n == 0 || out_ready);
  endfunction

  task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdy0", 108'(r0), 108'(exp_rdy(0, q0.size())));
    chk("val0", 108'(v0), 108'(q0.size() > 0));
    chk("ctrl0", 108'(c0), 108'(q0.size() > 0 ? q0[0][107:101] : NOP0));
    chk("data0", 108'(d0), 108'(q0.size() > 0 ? q0[0][100:0] : last0));
    chk("cnt0", 108'(f0), 108'(cnt0));
    chk("rdy1", 108'(r1), 108'(exp_rdy(1, q1.size())));
    chk("val1", 108'(v1), 108'(q1.size() > 0));
    chk("ctrl1", 108'(c1), 108'(q1.size() > 0 ? q1[0][107:101] : NOP1));
    chk("data1", 108'(d1), 108'(q1.size() > 0 ? q1[0][100:0] : last1));
    chk("cnt1", 108'(f1), 108'(cnt1));
  endtask

  task automatic mstep(input bit skid, ref ent_t q[$], ref logic [100:0] last, ref logic [15:0] cnt);
    bit ix, ox;
    ix = in_valid && exp_rdy(skid, q.size());
    ox = q.size() > 0 && out_ready;
    if (q.size() > 0) last = q[0][100:0];
    if (flush) begin
      if (q.size() > 0 && cnt != 16'hFFFF) cnt++;
      q.delete();
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back({in_ctrl, in_data});
    end
    if (q.size() > 0) last = q[0][100:0];
  endtask

  task automatic cyc(input bit v, input logic [100:0] d, input bit r, input bit f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    in_ctrl = 7'($urandom);
    if (v0 && r) outs0++;
    @(posedge clk);
    mstep(0, q0, last0, cnt0);
    mstep(1, q1, last1, cnt1);
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0 = 0;
    last1 = 0;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1;
    cyc(1, 101'h1234, 1, 0);
    chk("single_pass", 108'(d1), 108'h1234);
    cyc(0, 0, 1, 0);
    cyc(1, 101'h1, 0, 0);
    cyc(1, 101'h2, 0, 0);
    chk("bp_full_rdy", 108'(r1), 108'(0));
    cyc(0, 0, 1, 0);
    chk("bp_b_second", 108'(d1), 108'h2);
    cyc(0, 0, 1, 0);
    outs0 = 0;
    for (int i = 0; i < 100; i++) cyc(1, 101'(i + 1), 1, 0);
    cyc(0, 0, 1, 0);
    chk("stream_count", 108'(outs0), 108'(100));
    cyc(1, 101'hA, 0, 0);
    cyc(1, 101'hB, 0, 0);
    cyc(1, 101'hC, 0, 1);
    chk("flush_cnt_one", 108'(f1), 108'(1));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    force u1.flush_cnt = 16'hFFFE;
    #1 release u1.flush_cnt;
    cnt1 = 16'hFFFE;
    cyc(1, 101'h5, 0, 0);
    cyc(0, 0, 0, 1);
    chk("sat_first", 108'(f1), 108'hFFFF);
    cyc(1, 101'h6, 0, 0);
    cyc(0, 0, 0, 1);
    chk("sat_second", 108'(f1), 108'hFFFF);
    cyc(0, 0, 0, 1);
    cyc(1, 101'h7, 0, 0);
    cyc(1, 101'h8, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_val1", 108'(v1), 108'(0));
    chk("arst_rdy1", 108'(r1), 108'(1));
    chk("arst_val0", 108'(v0), 108'(0));
    chk("arst_cnt1", 108'(f1), 108'(0));
    #1 rst_n = 1;
    cyc(1, 101'h9, 0, 0);
    chk("post_rst_first", 108'(d1), 108'h9);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 1500; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), rnd[100:0], $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL take parameter DATA_W, default 101, giving the payload width in bits.
REQ-002 The module SHALL take parameter CTRL_W, default 7, giving the control-bundle width in bits.
REQ-003 The module SHALL take parameter SKID, default 1, which selects the buffer mode: 0 = single entry with combinational ready, 1 = two entries with registered ready.
REQ-004 The module SHALL take parameter NOP_CTRL, default all-zero CTRL_W constant, giving the bubble control value.
REQ-005 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 The module SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-008 The module SHALL have port in_valid  input  1  upstream entry present.
REQ-009 The module SHALL have port in_ready  output  1  stage can accept an entry.
REQ-010 The module SHALL have port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-011 The module SHALL have port in_data  input  DATA_W  upstream data bundle.
REQ-012 The module SHALL have port out_valid  output  1  held entry presented downstream.
REQ-013 The module SHALL have port out_ready  input  1  downstream accepts.
REQ-014 The module SHALL have port out_ctrl  output  CTRL_W  control of the presented entry, or NOP_CTRL.
REQ-015 The module SHALL have port out_data  output  DATA_W  data of the presented entry.
REQ-016 The module SHALL have port flush_cnt  output  16  saturating count of flushes that killed at least one valid entry.

Function
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-018 Latency from input transfer to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-019 Entries SHALL leave the stage in arrival order; no entry is dropped or duplicated except by flush.
REQ-020 In SKID=0 mode, in_ready SHALL be (!full || out_ready), and capacity SHALL be 1 entry.
REQ-021 In SKID=1 mode, the stage SHALL be a main register plus a skid register.
REQ-022 In SKID=1 mode, in_ready SHALL be driven from a flop equal to !skid_valid, with no combinational path from out_ready.
REQ-023 In SKID=1 mode, an input arriving while main is valid and not leaving SHALL be captured in skid.
REQ-024 In SKID=1 mode, when main leaves, skid (if valid) SHALL move to main in the same edge.
REQ-025 In SKID=1 mode, simultaneous input and output transfers with skid empty SHALL replace main, leaving occupancy unchanged.
REQ-026 The SKID=1 states SHALL be EMPTY (0 entries), ONE (main only) and FULL (main + skid); other states are illegal.
REQ-027 EMPTY SHALL transition to ONE on an input transfer.
REQ-028 ONE SHALL transition to EMPTY on output only, to FULL on input only, and stay in ONE on both.
REQ-029 FULL SHALL transition to ONE on output; input is impossible in FULL because in_ready=0.
REQ-030 When out_valid=0, out_ctrl SHALL equal NOP_CTRL, and out_data SHALL hold its last value.
REQ-031 A flush SHALL move the stage to EMPTY on the next edge, clear both valid bits, and set in_ready=1 in the following cycle.
REQ-032 Flush SHALL take priority over a same-cycle input transfer, which is discarded; the upstream side treats it as accepted.
REQ-033 A same-cycle output transfer during flush SHALL still count as delivered downstream.
REQ-034 flush_cnt SHALL increment by 1 when flush=1 and at least one entry is valid, and SHALL saturate at 0xFFFF.
REQ-035 Data and control SHALL pass bit-exact; there is no width conversion.

Reset
REQ-036 While rst_n=0, the stage SHALL be EMPTY, out_valid=0, out_ctrl=NOP_CTRL, out_data=0, flush_cnt=0, and in_ready=1 (SKID=1 flop reset to 1).
REQ-037 Reset assertion mid-transfer SHALL discard all held entries immediately without waiting for clk.
REQ-038 The first transfer after rst_n deasserts SHALL be accepted on the first rising edge after deassertion.

Verification
REQ-039 Single pass: SKID=1, in_valid=1, in_data=0x1234, out_ready=1 -> out_valid=1, out_data=0x1234 exactly one cycle later; in_ready stays 1.
REQ-040 Backpressure: SKID=1, out_ready=0, send A=0x1 then B=0x2 -> in_ready=0 after B; when out_ready=1 is raised, A then B emerge on consecutive cycles and in_ready returns to 1.
REQ-041 Streaming: SKID=0, in_valid=out_ready=1 for 100 cycles with incrementing data -> 100 outputs in order, with throughput of 1 per cycle.
REQ-042 Flush priority: SKID=1 FULL with A,B, flush=1 with in_valid=1 and C -> next cycle out_valid=0, out_ctrl=NOP_CTRL, C never emerges, flush_cnt=1.
REQ-043 Saturation/empty flush: flush_cnt forced to 0xFFFE, two flushes with entries valid -> reads 0xFFFF twice; a flush while EMPTY -> count unchanged.
REQ-044 Async reset: rst_n pulsed low between clock edges while FULL -> out_valid=0 and in_ready=1 immediately, with no output on the next edge.
